key_event_gen: RTL and testbench
================================

# key_event_gen

Keyboard-side producer of discrete key events for the game FSMs. It samples the raw held keycode from the USB keyboard path once per video frame and turns it into one press event per new key. When auto-repeat is compiled in, a held key also produces repeat events. Events are delivered through a 2-entry valid/ready queue, so consumers (team select, move select) act exactly once per event instead of re-testing a level keycode every frame.

## Interface
Parameters:
- `KEYCODE_W`, 8: keycode width.
- `REPEAT_DELAY`, 20: frame ticks a key must stay held after its press event before the first repeat (1..255).
- `REPEAT_PERIOD`, 6: frame ticks between subsequent repeats (1..255).

Ports:
- `Clk`, in, 1: system clock; the only clock.
- `Reset`, in, 1: asynchronous, active-low reset (0 = reset).
- `keycode`, in, KEYCODE_W: raw held keycode, already in the `Clk` domain; 0 = no key.
- `frame_clk`, in, 1: vsync-rate level; rising edges define frame ticks.
- `key_valid`, out, 1: queue head holds an event.
- `key_code`, out, KEYCODE_W: keycode of the head event; 0 when empty.
- `key_ready`, in, 1: consumer accepts the head event on this edge when `key_valid`=1.
- `key_held`, out, 1: a nonzero key is currently tracked (state ≠ IDLE).
- `dropped`, out, 1: sticky; an event was lost because the queue was full. Cleared only by reset.

## Operation
- Tick detect: `frame_clk` registered into `f_d1`, then `f_d2`. `tick` = `f_d1 & ~f_d2`. One tick per frame_clk rising edge, lasting exactly one Clk cycle.
- Internal registers:
  - `state` ∈ {IDLE, DELAY, REPEAT}.
  - `last` (KEYCODE_W): keycode currently tracked.
  - `cnt` (8-bit): tick counter.
- All transitions occur only on `tick` cycles. Let k = `keycode` sampled that cycle.
  - k = 0 (any state): go to IDLE; `last`=0; `cnt`=0; no event.
  - k ≠ 0 and k ≠ `last` (any state, including a key switch while held): push event k; `last`=k; `cnt`=0; go to DELAY.
  - k = `last` ≠ 0, state DELAY: `cnt`+1. When `cnt`+1 = REPEAT_DELAY: push k, `cnt`=0, go to REPEAT.
  - k = `last` ≠ 0, state REPEAT: `cnt`+1. When `cnt`+1 = REPEAT_PERIOD: push k, `cnt`=0.
- Queue: 2-entry circular buffer with 1-bit read/write pointers and a 2-bit count.
  - `key_valid` = (count ≠ 0).
  - `key_code` = head entry when valid, else 0.
  - Pop occurs when `key_valid & key_ready`.
- Boundary cases:
  - Push and pop in the same cycle at full (count 2): both succeed, and count stays 2.
  - Push at full with no pop: the event is discarded, `dropped`←1, and the queue is unchanged. The state machine advances regardless.
  - Push and pop in the same cycle at count 1: count stays 1, and the new head is the pushed event.
  - `key_ready` while empty: ignored.
  - `cnt` never exceeds max(REPEAT_DELAY, REPEAT_PERIOD) − 1. No wrap is possible.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; `last`, `cnt`, `f_d1`, `f_d2` = 0; queue empty.
  - Outputs: `key_valid`=0, `key_code`=0, `key_held`=0, `dropped`=0.
- Reset asserted mid-operation clears all queued events immediately and asynchronously.
- Latency:
  - frame_clk rising edge to `tick`: 2 Clk edges.
  - `tick` edge to `key_valid`=1: visible in the cycle after that edge.
- `key_held` is registered and updates on the same edge as `state`.
- A key held for N ticks after its press produces its first repeat exactly REPEAT_DELAY ticks after the press event, then one every REPEAT_PERIOD ticks.
- `keycode` changes between ticks are invisible. Only tick-cycle samples matter.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: DELAY/REPEAT counting and repeat events behave as described above.
- Not defined:
  - No repeat events are generated; the `cnt` logic is compiled out.
  - A held key stays in DELAY indefinitely.
  - Only press events are generated: a new nonzero key, or a key change.
  - REPEAT_DELAY and REPEAT_PERIOD are unused.

## Test plan
- Reset, then keycode=8'h1A for 1 tick, then 0 with `key_ready`=1 → exactly one event with `key_code`=8'h1A; `key_held` goes 1 then 0; `dropped`=0.
- `KEY_AUTOREPEAT_EN`, REPEAT_DELAY=3, REPEAT_PERIOD=2, hold 8'h07 for 8 ticks, `key_ready`=1 → events on ticks 1, 4, 6, 8 (four events total).
- Without macro, same stimulus → exactly one event (8'h07).
- `key_ready`=0; keys 8'h04, 8'h16, 8'h1A on three consecutive ticks → queue holds 8'h04 then 8'h16; `dropped`=1. Then `key_ready`=1 → pops 8'h04, then 8'h16, then `key_valid`=0.
- Queue full (8'h04, 8'h16), `key_ready`=1 held on the same cycle as a push of 8'h07 → count stays 2; order is 8'h16 then 8'h07; `dropped` stays 0.
- Hold 8'h1A; deassert `Reset` for one cycle between ticks → `key_valid`=0, `key_held`=0 immediately. The next tick with 8'h1A produces a fresh press event.

Source files
------------

// File: rtl/key_event_gen.sv
// key_event_gen
//   Turns the raw held keycode into discrete key events, one per new key,
//   sampled once per video frame. Events go into a 2-entry valid/ready queue.
//
//   Build option: define KEY_AUTOREPEAT_EN to enable repeat events for a held
//   key: the first repeat comes REPEAT_DELAY ticks after the press, then one
//   every REPEAT_PERIOD ticks. Without it only press events are produced, and
//   REPEAT_DELAY / REPEAT_PERIOD have no effect.
//
//   Ports:
//     Clk        in   system clock
//     Reset      in   async active-low reset
//     keycode    in   raw held keycode (0 = no key), Clk domain
//     frame_clk  in   vsync-rate level; rising edges are frame ticks
//     key_valid  out  queue head holds an event
//     key_code   out  head event keycode (0 when empty)
//     key_ready  in   consumer pops the head when key_valid=1
//     key_held   out  a nonzero key is being tracked
//     dropped    out  sticky: an event was lost to a full queue
module key_event_gen #(
    parameter int KEYCODE_W     = 8,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 6
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [KEYCODE_W-1:0] keycode,
    input  logic                 frame_clk,
    output logic                 key_valid,
    output logic [KEYCODE_W-1:0] key_code,
    input  logic                 key_ready,
    output logic                 key_held,
    output logic                 dropped
);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

    state_t                r_state, w_state_nx;
    logic                  r_f_d1, r_f_d2, w_tick;
    logic [KEYCODE_W-1:0]  r_last, w_last_nx;
    logic                  w_push;
    logic                  r_held;
    logic                  r_dropped;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [7:0] LP_DELAY  = 8'(REPEAT_DELAY);
    localparam logic [7:0] LP_PERIOD = 8'(REPEAT_PERIOD);
    logic [7:0] r_cnt, w_cnt_nx, w_cnt_inc;
`endif

    // Queue storage and pointers
    logic [1:0][KEYCODE_W-1:0] r_q;
    logic                      r_wp, r_rp;
    logic [1:0]                r_qcnt;
    logic                      w_pop, w_full, w_wr, w_drop;

    // Frame tick: one Clk cycle per frame_clk rising edge
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_f_d1 <= 1'b0;
            r_f_d2 <= 1'b0;
        end else begin
            r_f_d1 <= frame_clk;
            r_f_d2 <= r_f_d1;
        end
    end
    assign w_tick = r_f_d1 & ~r_f_d2;

    // Tracker state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_last  <= '0;
            r_held  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            r_cnt   <= 8'd0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_last  <= w_last_nx;
            r_held  <= (w_state_nx != ST_IDLE);
`ifdef KEY_AUTOREPEAT_EN
            r_cnt   <= w_cnt_nx;
`endif
        end
    end

    // Tracker next state; only tick cycles change anything
    always_comb begin
        w_state_nx = r_state;
        w_last_nx  = r_last;
        w_push     = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        w_cnt_nx   = r_cnt;
        w_cnt_inc  = r_cnt + 8'd1;
`endif
        if (w_tick) begin
            if (keycode == '0) begin
                w_state_nx = ST_IDLE;
                w_last_nx  = '0;
`ifdef KEY_AUTOREPEAT_EN
                w_cnt_nx   = 8'd0;
`endif
            end else if (keycode != r_last) begin
                // New key or key switch while held: fresh press
                w_push     = 1'b1;
                w_last_nx  = keycode;
                w_state_nx = ST_DELAY;
`ifdef KEY_AUTOREPEAT_EN
                w_cnt_nx   = 8'd0;
            end else if (r_state == ST_DELAY) begin
                if (w_cnt_inc == LP_DELAY) begin
                    w_push     = 1'b1;
                    w_cnt_nx   = 8'd0;
                    w_state_nx = ST_REPEAT;
                end else begin
                    w_cnt_nx   = w_cnt_inc;
                end
            end else if (r_state == ST_REPEAT) begin
                if (w_cnt_inc == LP_PERIOD) begin
                    w_push   = 1'b1;
                    w_cnt_nx = 8'd0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
`endif
            end
        end
    end

    // Queue control. At full with a simultaneous pop, the write slot equals
    // the slot being popped, so the write safely reuses it.
    assign w_pop  = key_valid & key_ready;
    assign w_full = (r_qcnt == 2'd2);
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_q       <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_qcnt    <= 2'd0;
            r_dropped <= 1'b0;
        end else begin
            if (w_wr) r_q[r_wp] <= keycode;
            r_wp <= r_wp ^ w_wr;
            r_rp <= r_rp ^ w_pop;
            case ({w_wr, w_pop})
                2'b10:   r_qcnt <= r_qcnt + 2'd1;
                2'b01:   r_qcnt <= r_qcnt - 2'd1;
                default: r_qcnt <= r_qcnt;
            endcase
            if (w_drop) r_dropped <= 1'b1;
        end
    end

    assign key_valid = (r_qcnt != 2'd0);
    assign key_code  = key_valid ? r_q[r_rp] : '0;
    assign key_held  = r_held;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: a directed vector table, hand-written corner
// sequences, and a randomized phase, all checked every cycle against an
// event-level reference model (ticks held since press, plus a queue).
module tb_key_event_gen;
    localparam int W  = 8;
    localparam int RD = 3;
    localparam int RP = 2;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic [W-1:0] keycode = '0;
    logic         frame_clk = 1'b0;
    logic         key_ready = 1'b0;
    logic         key_valid, key_held, dropped;
    logic [W-1:0] key_code;

    key_event_gen #(.KEYCODE_W(W), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .key_held(key_held), .dropped(dropped)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [W-1:0] mq[$];
    bit           m_fd1, m_fd2, m_drop;
    logic [W-1:0] m_last;
    int           m_n;          // ticks since last press of m_last
    int           dut_acc;      // handshakes seen on the DUT interface
    logic [W-1:0] dut_acc_last;

    function automatic void m_reset();
        mq.delete();
        m_fd1 = 0; m_fd2 = 0; m_drop = 0; m_last = '0; m_n = 0;
    endfunction

    // Advance the model over one clock edge using the pre-edge inputs
    function automatic void m_step();
        bit tick, ev, pop;
        int sz;
        logic [W-1:0] ek;
        tick = m_fd1 && !m_fd2;
        m_fd2 = m_fd1;
        m_fd1 = frame_clk;
        ev = 0; ek = '0;
        if (tick) begin
            if (keycode == '0) begin
                m_last = '0; m_n = 0;
            end else if (keycode != m_last) begin
                ev = 1; ek = keycode; m_last = keycode; m_n = 0;
            end else begin
                m_n++;
`ifdef KEY_AUTOREPEAT_EN
                if (m_n >= RD && ((m_n - RD) % RP) == 0) begin
                    ev = 1; ek = keycode;
                end
`endif
            end
        end
        sz  = mq.size();
        pop = (sz != 0) && key_ready;
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (sz == 2 && !pop) m_drop = 1;
            else mq.push_back(ek);
        end
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model on posedge, compare on negedge, caller drives after
    task automatic cyc();
        @(posedge Clk);
        if (Reset) m_step();
        @(negedge Clk);
        cmp("valid", key_valid, mq.size() != 0);
        cmp("code", key_code, (mq.size() != 0) ? mq[0] : '0);
        cmp("held", key_held, m_last != '0);
        cmp("dropped", dropped, m_drop);
        if (key_valid && key_ready) begin
            dut_acc++;
            dut_acc_last = key_code;
        end
    endtask

    task automatic do_tick(input logic [W-1:0] k, input logic r);
        keycode = k; key_ready = r; frame_clk = 1'b1;
        repeat (3) cyc();
        frame_clk = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic do_reset();
        Reset = 1'b0; key_ready = 1'b0; frame_clk = 1'b0; keycode = '0;
        m_reset();
        repeat (2) cyc();
        Reset = 1'b1;
        cyc();
    endtask

    typedef struct {
        logic [W-1:0] k;
        logic         r;
        logic         v;
        logic [W-1:0] c;
        logic         h;
        logic         d;
    } vec_t;

    vec_t tbl[7];
    logic [W-1:0] ks[4];

    initial begin
        // k, ready -> valid, code, held, dropped after the tick window
        tbl[0] = '{8'h04, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0};
        tbl[1] = '{8'h16, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0};
        tbl[2] = '{8'h1A, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{8'h1A, 1'b0, 1'b1, 8'h1A, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b1};
        tbl[6] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        ks = '{8'h00, 8'h04, 8'h07, 8'h16};
        dut_acc = 0; dut_acc_last = '0;

        // Reset values
        m_reset();
        @(negedge Clk);
        cmp("rst_valid", key_valid, 1'b0);
        cmp("rst_code", key_code, 8'h00);
        cmp("rst_held", key_held, 1'b0);
        cmp("rst_dropped", dropped, 1'b0);
        do_reset();

        // Table: fill, overflow, drain
        for (int i = 0; i < 7; i++) begin
            do_tick(tbl[i].k, tbl[i].r);
            cmp($sformatf("tbl%0d_valid", i), key_valid, tbl[i].v);
            cmp($sformatf("tbl%0d_code", i), key_code, tbl[i].c);
            cmp($sformatf("tbl%0d_held", i), key_held, tbl[i].h);
            cmp($sformatf("tbl%0d_dropped", i), dropped, tbl[i].d);
        end

        // Single press consumed once
        do_reset();
        dut_acc = 0;
        do_tick(8'h1A, 1'b1);
        cmp("press_held", key_held, 1'b1);
        do_tick(8'h00, 1'b1);
        cmp("press_count", dut_acc, 1);
        cmp("press_code", dut_acc_last, 8'h1A);
        cmp("press_unheld", key_held, 1'b0);
        cmp("press_dropped", dropped, 1'b0);

        // Held key for 8 ticks
        do_reset();
        dut_acc = 0;
        repeat (8) do_tick(8'h07, 1'b1);
`ifdef KEY_AUTOREPEAT_EN
        cmp("hold_count", dut_acc, 4);
`else
        cmp("hold_count", dut_acc, 1);
`endif
        cmp("hold_code", dut_acc_last, 8'h07);
        do_tick(8'h00, 1'b1);

        // Push and pop in the same cycle at full
        do_reset();
        do_tick(8'h04, 1'b0);
        do_tick(8'h16, 1'b0);
        keycode = 8'h07; frame_clk = 1'b1;
        cyc();                       // f_d1 rises; tick is active next edge
        key_ready = 1'b1;
        cyc();                       // push 07 and pop 04 together
        key_ready = 1'b0;
        cmp("full_pp_valid", key_valid, 1'b1);
        cmp("full_pp_head", key_code, 8'h16);
        cmp("full_pp_dropped", dropped, 1'b0);
        key_ready = 1'b1;
        cyc();
        cmp("full_pp_second", key_code, 8'h07);
        cyc();
        cmp("full_pp_empty", key_valid, 1'b0);
        key_ready = 1'b0; frame_clk = 1'b0;
        repeat (3) cyc();

        // Async reset while a key is held
        do_reset();
        do_tick(8'h1A, 1'b0);
        cmp("areset_pre_valid", key_valid, 1'b1);
        Reset = 1'b0;
        m_reset();
        #1;
        cmp("areset_valid", key_valid, 1'b0);
        cmp("areset_code", key_code, 8'h00);
        cmp("areset_held", key_held, 1'b0);
        cyc();
        Reset = 1'b1;
        cyc();
        do_tick(8'h1A, 1'b0);
        cmp("areset_repress_valid", key_valid, 1'b1);
        cmp("areset_repress_code", key_code, 8'h1A);
        cmp("areset_repress_held", key_held, 1'b1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(15) == 0) keycode = ks[$urandom_range(3)];
            key_ready = ($urandom_range(2) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
